// File: rtl/skolem_witness_checker_if.sv
// Operand/witness bus between the sweep checker and the Skolem block under test.
// The checker presents (s,t) and reads the witness x back.
interface skolem_witness_checker_if #(
  parameter int W = 4
);
  logic [W-1:0] s_out;
  logic [W-1:0] t_out;
  logic [W-1:0] x_in;

  modport master (output s_out, output t_out, input x_in);
  modport slave  (input s_out, input t_out, output x_in);
endinterface

// File: rtl/skolem_witness_checker.sv
// Exhaustive checker for the "(x >>u s) <s t" invertibility Skolem function:
// sweeps every (s,t), brute-forces existence of a witness and grades the supplied x.
module skolem_witness_checker #(
  parameter int W            = 4,
  parameter int SKOLEM_LAT   = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  skolem_witness_checker_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [2*W:0]             fail_count,
  output logic [2*W:0]             vacuous_count,
  output logic                     fail_valid,
  output logic [W-1:0]             ff_s,
  output logic [W-1:0]             ff_t,
  output logic [W-1:0]             ff_x
);

  localparam int LAT_W = (SKOLEM_LAT < 1) ? 1 : $clog2(SKOLEM_LAT + 1);
  localparam int CW    = 2 * W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_SWEEP = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   idx_q, idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [W-1:0]     k_q, k_d;
  logic             exists_q, exists_d;
  logic [W-1:0]     x_cap_q, x_cap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CW-1:0]    fail_cnt_q, fail_cnt_d;
  logic [CW-1:0]    vac_cnt_q, vac_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [W-1:0]     ff_s_q, ff_s_d;
  logic [W-1:0]     ff_t_q, ff_t_d;
  logic [W-1:0]     ff_x_q, ff_x_d;

  logic [W-1:0]     cur_s_s;
  logic [W-1:0]     cur_t_s;
  logic             ok_s;
  logic             stop_s;

  // The formula under test; a shift of W or more clears the operand.
  function automatic logic sat(input logic [W-1:0] x, input logic [W-1:0] s,
                               input logic [W-1:0] t);
    logic [W-1:0] sh;
    if (int'(s) >= W) begin
      sh = {W{1'b0}};
    end else begin
      sh = x >> s;
    end
    return $signed(sh) < $signed(t);
  endfunction

  assign cur_s_s = idx_q[W-1:0];
  assign cur_t_s = idx_q[2*W-1:W];

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    k_d          = k_q;
    exists_d     = exists_q;
    x_cap_d      = x_cap_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    vac_cnt_d    = vac_cnt_q;
    fail_valid_d = fail_valid_q;
    ff_s_d       = ff_s_q;
    ff_t_d       = ff_t_q;
    ff_x_d       = ff_x_q;
    ok_s         = sat(x_cap_q, cur_s_s, cur_t_s);
    stop_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_DRIVE;
          idx_d        = {(2*W){1'b0}};
          lat_d        = {LAT_W{1'b0}};
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_cnt_d   = {CW{1'b0}};
          vac_cnt_d    = {CW{1'b0}};
          fail_valid_d = 1'b0;
          ff_s_d       = {W{1'b0}};
          ff_t_d       = {W{1'b0}};
          ff_x_d       = {W{1'b0}};
        end else begin
          busy_d = 1'b0;
        end
      end
      S_DRIVE: begin
        if (lat_q == LAT_W'(SKOLEM_LAT)) begin
          x_cap_d  = bus.x_in;
          k_d      = {W{1'b0}};
          exists_d = 1'b0;
          state_d  = S_SWEEP;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_SWEEP: begin
        exists_d = exists_q | sat(k_q, cur_s_s, cur_t_s);
        if (k_q == {W{1'b1}}) begin
          state_d = S_CHECK;
        end else begin
          k_d = k_q + W'(1);
        end
      end
      S_CHECK: begin
        if (!exists_q) begin
          vac_cnt_d = vac_cnt_q + CW'(1);
        end else if (!ok_s) begin
          fail_cnt_d = fail_cnt_q + CW'(1);
          stop_s     = (STOP_ON_FAIL != 0);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            ff_s_d       = cur_s_s;
            ff_t_d       = cur_t_s;
            ff_x_d       = x_cap_q;
          end else begin
            fail_valid_d = fail_valid_q;
          end
        end else begin
          vac_cnt_d = vac_cnt_q;
        end
        // Pass is evaluated with this pair's outcome already folded in.
        if (stop_s || (idx_q == {(2*W){1'b1}})) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == {CW{1'b0}});
        end else begin
          idx_d   = idx_q + (2*W)'(1);
          lat_d   = {LAT_W{1'b0}};
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= {(2*W){1'b0}};
      lat_q        <= {LAT_W{1'b0}};
      k_q          <= {W{1'b0}};
      exists_q     <= 1'b0;
      x_cap_q      <= {W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= {CW{1'b0}};
      vac_cnt_q    <= {CW{1'b0}};
      fail_valid_q <= 1'b0;
      ff_s_q       <= {W{1'b0}};
      ff_t_q       <= {W{1'b0}};
      ff_x_q       <= {W{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      k_q          <= k_d;
      exists_q     <= exists_d;
      x_cap_q      <= x_cap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      vac_cnt_q    <= vac_cnt_d;
      fail_valid_q <= fail_valid_d;
      ff_s_q       <= ff_s_d;
      ff_t_q       <= ff_t_d;
      ff_x_q       <= ff_x_d;
    end
  end

  assign bus.s_out     = cur_s_s;
  assign bus.t_out     = cur_t_s;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_count    = fail_cnt_q;
  assign vacuous_count = vac_cnt_q;
  assign fail_valid    = fail_valid_q;
  assign ff_s          = ff_s_q;
  assign ff_t          = ff_t_q;
  assign ff_x          = ff_x_q;

endmodule

// File: tb/tb_skolem_witness_checker.sv
// Directed bench for skolem_witness_checker: three checker instances (plain,
// stop-on-fail, latency 2) driven by reference, tied-off and delayed Skolem models.
module tb_skolem_witness_checker;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  int   mode0 = 0;   // 0 reference, 1 tied to zero, 2 reference delayed by two cycles

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  skolem_witness_checker_if #(.W(W)) bus0 ();
  skolem_witness_checker_if #(.W(W)) bus1 ();
  skolem_witness_checker_if #(.W(W)) bus2 ();

  logic         busy0, done0, pass0, fv0;
  logic         busy1, done1, pass1, fv1;
  logic         busy2, done2, pass2, fv2;
  logic [2*W:0] fc0, vc0, fc1, vc1, fc2, vc2;
  logic [W-1:0] fs0, ft0, fx0, fs1, ft1, fx1, fs2, ft2, fx2;

  // A correct witness: -8 reaches every t but -8 when s=0; 0 is the least reachable value otherwise.
  function automatic logic [W-1:0] refx(input logic [W-1:0] s);
    return (s == 4'd0) ? 4'h8 : 4'h0;
  endfunction

  logic [W-1:0] d0_1 = 4'h0, d0_2 = 4'h0, d2_1 = 4'h0, d2_2 = 4'h0;
  always @(posedge clk) begin
    d0_1 <= refx(bus0.s_out);
    d0_2 <= d0_1;
    d2_1 <= refx(bus2.s_out);
    d2_2 <= d2_1;
  end

  assign bus0.x_in = (mode0 == 0) ? refx(bus0.s_out) : (mode0 == 1) ? 4'h0 : d0_2;
  assign bus1.x_in = 4'h0;
  assign bus2.x_in = d2_2;

  skolem_witness_checker #(.W(W), .SKOLEM_LAT(0), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0.master),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0), .vacuous_count(vc0),
    .fail_valid(fv0), .ff_s(fs0), .ff_t(ft0), .ff_x(fx0));

  skolem_witness_checker #(.W(W), .SKOLEM_LAT(0), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .vacuous_count(vc1),
    .fail_valid(fv1), .ff_s(fs1), .ff_t(ft1), .ff_x(fx1));

  skolem_witness_checker #(.W(W), .SKOLEM_LAT(2), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2.master),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(fc2), .vacuous_count(vc2),
    .fail_valid(fv2), .ff_s(fs2), .ff_t(ft2), .ff_x(fx2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic get_busy(input int which);
    return (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 0) ? done0 : (which == 1) ? done1 : done2;
  endfunction

  // One start pulse, then watch busy/done until 30 cycles past the first done (bounded).
  task automatic run(input int which, input bit repulse, output int bcyc,
                     output int ndone, output int rise_to_done);
    int first_busy;
    int first_done;
    first_busy = -1; first_done = -1;
    bcyc = 0; ndone = 0; rise_to_done = -1;
    @(negedge clk);
    set_start(which, 1'b1);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      set_start(which, 1'b0);
      if (get_busy(which)) begin
        bcyc++;
        if (first_busy < 0) first_busy = c;
      end
      if (get_done(which)) begin
        ndone++;
        if (first_done < 0) begin
          first_done = c;
          if (repulse) set_start(which, 1'b1);
        end
      end else if (repulse && get_busy(which) && (c % 97 == 5)) begin
        set_start(which, 1'b1);
      end
      if (first_done >= 0 && c >= first_done + 30) break;
    end
    if (first_done >= 0 && first_busy >= 0) rise_to_done = first_done - first_busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int bc, nd, rtd, extra_done;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs0",
          {busy0, done0, pass0, fv0, fc0, vc0, fs0, ft0, fx0, bus0.s_out, bus0.t_out}, 64'd0);
    rst_n = 1'b1;

    // 1: reference model, LAT=0
    mode0 = 0;
    run(0, 1'b0, bc, nd, rtd);
    check("s1_busy_cycles", 64'(bc), 64'd4608);
    check("s1_done_pulses", 64'(nd), 64'd1);
    check("s1_pass", 64'(pass0), 64'd1);
    check("s1_fail_count", 64'(fc0), 64'd0);
    check("s1_vacuous", 64'(vc0), 64'd136);
    check("s1_fail_valid", 64'(fv0), 64'd0);
    check("s1_last_pair", {56'd0, bus0.t_out, bus0.s_out}, 64'hFF);

    // 2: witness tied to zero
    mode0 = 1;
    run(0, 1'b0, bc, nd, rtd);
    check("s2_fail_count", 64'(fc0), 64'd8);
    check("s2_vacuous", 64'(vc0), 64'd136);
    check("s2_pass", 64'(pass0), 64'd0);
    check("s2_fail_valid", 64'(fv0), 64'd1);
    check("s2_first_fail", {52'd0, fs0, ft0, fx0}, 64'd0);

    // 3: tied to zero, stop on first failure
    run(1, 1'b0, bc, nd, rtd);
    check("s3_rise_to_done", 64'(rtd), 64'd18);
    check("s3_fail_count", 64'(fc1), 64'd1);
    check("s3_vacuous", 64'(vc1), 64'd0);
    check("s3_pass", 64'(pass1), 64'd0);
    check("s3_first_fail", {51'd0, fv1, fs1, ft1, fx1}, 64'h1000);
    check("s3_pair_hold", {56'd0, bus1.t_out, bus1.s_out}, 64'd0);

    // 4: two-cycle delayed model, with and without matching latency
    run(2, 1'b0, bc, nd, rtd);
    check("s4_busy_cycles", 64'(bc), 64'd5120);
    check("s4_pass", 64'(pass2), 64'd1);
    check("s4_fail_count", 64'(fc2), 64'd0);
    check("s4_vacuous", 64'(vc2), 64'd136);
    mode0 = 2;
    run(0, 1'b0, bc, nd, rtd);
    check("s4_lat0_has_fails", 64'(fc0 != 9'd0), 64'd1);
    check("s4_lat0_pass", 64'(pass0), 64'd0);

    // 5: reset at mid-sweep cycle 1000
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (999) @(negedge clk);
    check("s5_busy_before_reset", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("s5_outputs_zero",
          {busy0, done0, pass0, fv0, fc0, vc0, fs0, ft0, fx0, bus0.s_out, bus0.t_out}, 64'd0);
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) extra_done++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done0 || busy0) extra_done++;
    end
    check("s5_no_done_after_abort", 64'(extra_done), 64'd0);
    run(0, 1'b0, bc, nd, rtd);
    check("s5_rerun_busy", 64'(bc), 64'd4608);
    check("s5_rerun_result", {45'd0, pass0, fc0, vc0}, {45'd0, 1'b1, 9'd0, 9'd136});

    // 6: start pulsed repeatedly while busy and during done
    run(0, 1'b1, bc, nd, rtd);
    check("s6_busy_cycles", 64'(bc), 64'd4608);
    check("s6_done_pulses", 64'(nd), 64'd1);
    check("s6_result", {45'd0, pass0, fc0, vc0}, {45'd0, 1'b1, 9'd0, 9'd136});
    check("s6_idle_after", 64'(busy0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
